priority_encoder_lr: RTL and testbench

//  Registered two-sided priority encoder. On each valid input word, reports the

---
 rtl/priority_onehot_lsb.sv | 18 +
 rtl/priority_encoder_lr.sv | 66 ++++++
 tb/tb_priority_encoder_lr.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/priority_onehot_lsb.sv
// Combinational lowest-set-bit isolator: returns a one-hot vector marking the
// least-significant 1 of i_data, or all-zero when i_data is zero.
module priority_onehot_lsb #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] onehot_o
);

  logic [WIDTH-1:0] w_neg;

  // Two's complement negation; ANDing with the original leaves only the lowest 1.
  always_comb begin
    w_neg    = ~data_i + {{(WIDTH-1){1'b0}}, 1'b1};
    onehot_o = data_i & w_neg;
  end

endmodule

// File: rtl/priority_encoder_lr.sv
// Registered two-sided priority encoder: for each valid word, reports the
// highest set bit (left) and lowest set bit (right) as one-hot vectors, one
// cycle later. The left side reuses the lowest-bit isolator on the
// bit-reversed word and reverses the result back.
module priority_encoder_lr #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic             deser_data_val_o
);

  logic [WIDTH-1:0] w_data_rev;
  logic [WIDTH-1:0] w_left_rev;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;

  logic [WIDTH-1:0] r_left_p0;
  logic [WIDTH-1:0] r_right_p0;
  logic             r_vld_p0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev_in
    assign w_data_rev[g] = data_i[WIDTH-1-g];
  end

  priority_onehot_lsb #(.WIDTH(WIDTH)) u_lsb_right (
    .data_i   (data_i),
    .onehot_o (w_right)
  );

  priority_onehot_lsb #(.WIDTH(WIDTH)) u_lsb_left (
    .data_i   (w_data_rev),
    .onehot_o (w_left_rev)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev_out
    assign w_left[g] = w_left_rev[WIDTH-1-g];
  end

  // Output stage: capture results for accepted words, clear everything
  // otherwise so idle cycles and reset both present all-zero outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_left_p0  <= '0;
      r_right_p0 <= '0;
      r_vld_p0   <= 1'b0;
    end else if (data_val_i) begin
      r_left_p0  <= w_left;
      r_right_p0 <= w_right;
      r_vld_p0   <= 1'b1;
    end else begin
      r_left_p0  <= '0;
      r_right_p0 <= '0;
      r_vld_p0   <= 1'b0;
    end
  end

  assign data_left_o      = r_left_p0;
  assign data_right_o     = r_right_p0;
  assign deser_data_val_o = r_vld_p0;

endmodule

// File: tb/tb_priority_encoder_lr.sv
// Bench for priority_encoder_lr (WIDTH=16): directed vector table followed by
// a randomized regression against a loop-scan reference model.
module tb_priority_encoder_lr;

  localparam int W = 16;

  logic         clk_i;
  logic         srst_i;
  logic [W-1:0] data_i;
  logic         data_val_i;
  logic [W-1:0] data_left_o;
  logic [W-1:0] data_right_o;
  logic         deser_data_val_o;

  int checks;
  int failures;

  typedef struct {
    logic         rst;
    logic         val;
    logic [W-1:0] data;
    logic [W-1:0] exp_left;
    logic [W-1:0] exp_right;
    logic         exp_val;
  } vec_t;

  vec_t tbl[$];

  priority_encoder_lr #(.WIDTH(W)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .data_left_o      (data_left_o),
    .data_right_o     (data_right_o),
    .deser_data_val_o (deser_data_val_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] ref_left(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (d[i]) r = W'(1) << i;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_right(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) if (d[i]) r = W'(1) << i;
    return r;
  endfunction

  function automatic int popcount(input logic [W-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic vec_t mk(input logic rst, input logic val, input logic [W-1:0] d,
                              input logic [W-1:0] el, input logic [W-1:0] er,
                              input logic ev);
    vec_t v;
    v.rst = rst; v.val = val; v.data = d;
    v.exp_left = el; v.exp_right = er; v.exp_val = ev;
    return v;
  endfunction

  // Apply one cycle of inputs after the falling edge and compare outputs just
  // after the following rising edge.
  task automatic step(input string name, input logic rst, input logic val,
                      input logic [W-1:0] d, input logic [W-1:0] el,
                      input logic [W-1:0] er, input logic ev);
    @(negedge clk_i);
    srst_i     = rst;
    data_val_i = val;
    data_i     = d;
    @(posedge clk_i);
    #1;
    checks++;
    if (data_left_o !== el) begin
      failures++;
      $display("FAIL %s left: got %h expected %h", name, data_left_o, el);
    end
    checks++;
    if (data_right_o !== er) begin
      failures++;
      $display("FAIL %s right: got %h expected %h", name, data_right_o, er);
    end
    checks++;
    if (deser_data_val_o !== ev) begin
      failures++;
      $display("FAIL %s valid: got %b expected %b", name, deser_data_val_o, ev);
    end
    checks++;
    if (popcount(data_left_o) > 1 || popcount(data_right_o) > 1) begin
      failures++;
      $display("FAIL %s onehot: got left=%h right=%h expected at most one bit each",
               name, data_left_o, data_right_o);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    logic         v;
    logic         r;

    checks     = 0;
    failures   = 0;
    srst_i     = 1'b1;
    data_val_i = 1'b0;
    data_i     = '0;

    // rst, val, data, exp_left, exp_right, exp_val
    tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'hABCD, 16'h0000, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0810, 16'h0800, 16'h0010, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h8001, 16'h8000, 16'h0001, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'hFFFF, 16'h8000, 16'h0001, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0040, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0003, 16'h0002, 16'h0001, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'hF000, 16'h8000, 16'h1000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0100, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'h7FFE, 16'h4000, 16'h0002, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b1));

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].val, tbl[i].data,
           tbl[i].exp_left, tbl[i].exp_right, tbl[i].exp_val);

    // Reset held mid-stream discards the word in flight, then resumes.
    step("rst_mid_a", 1'b0, 1'b1, 16'h0C30, 16'h0800, 16'h0010, 1'b1);
    step("rst_mid_b", 1'b1, 1'b1, 16'h0C30, 16'h0000, 16'h0000, 1'b0);
    step("rst_mid_c", 1'b0, 1'b1, 16'h0C30, 16'h0800, 16'h0010, 1'b1);

    // Randomized regression with mostly-valid traffic and rare resets.
    for (int n = 0; n < 1000; n++) begin
      d = W'($urandom);
      case ($urandom_range(0, 3))
        0: d = W'(1) << $urandom_range(0, W - 1);
        1: d = d & W'($urandom);
        default: ;
      endcase
      v = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 49) == 0);
      if (r || !v)
        step($sformatf("rnd%0d", n), r, v, d, '0, '0, 1'b0);
      else
        step($sformatf("rnd%0d", n), r, v, d, ref_left(d), ref_right(d), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
